// File: rtl/speed_pi_pwm.sv
// ----------------------------------------------------------------------------
// speed_pi_pwm
//
// Closed-loop speed stage placed after the quadrature decoder. Every
// SAMPLE_CYCLES clocks it compares the decoder velocity with the commanded
// velocity. A multi-cycle FSM evaluates a fixed-point PI law. The result
// drives a double-buffered PWM generator and an H-bridge direction line.
//
// Ports
//   clk_48      in   system clock (48 MHz)
//   reset       in   asynchronous, active-high reset
//   enable      in   loop enable; low forces PWM off and clears integrator
//   vel_cmd     in   [11:0] commanded velocity, two's complement
//   vel_meas    in   [11:0] measured velocity from decoder, two's complement
//   pwm_out     out  PWM gate drive (registered)
//   motor_dir   out  bridge direction, 1 = position increasing
//   duty        out  [10:0] duty currently applied by the PWM generator
//   sat         out  last computed output was clamped to PWM_PERIOD-1
//   update_done out  one-cycle strobe when a new duty has been computed
// ----------------------------------------------------------------------------
module speed_pi_pwm #(
    parameter int SAMPLE_CYCLES = 2502,
    parameter int PWM_PERIOD    = 1200,
    parameter int KP            = 16,
    parameter int KI            = 1,
    parameter int FRAC_BITS     = 4,
    parameter int INT_LIMIT     = 4095
) (
    input  logic        clk_48,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] vel_cmd,
    input  logic [11:0] vel_meas,
    output logic        pwm_out,
    output logic        motor_dir,
    output logic [10:0] duty,
    output logic        sat,
    output logic        update_done
);

    localparam int SW = $clog2(SAMPLE_CYCLES);
    localparam int CW = $clog2(PWM_PERIOD);
    localparam int IW = 16;  // integrator width: holds +-INT_LIMIT plus one error term

    localparam logic [SW-1:0]        SAMP_LAST  = SW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0]        CNT_LAST   = CW'(PWM_PERIOD - 1);
    localparam logic [10:0]          DUTY_MAX   = 11'(PWM_PERIOD - 1);
    localparam logic [31:0]          DUTY_MAX32 = 32'(PWM_PERIOD - 1);
    localparam logic signed [IW-1:0] INT_MAX    = IW'(INT_LIMIT);
    localparam logic signed [IW-1:0] INT_MIN    = -INT_MAX;
    localparam logic signed [31:0]   KP_S       = 32'(KP);
    localparam logic signed [31:0]   KI_S       = 32'(KI);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MUL,
        S_SUM,
        S_CLAMP
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [12:0]   err_q, err_d;
    logic signed [IW-1:0] integ_q, integ_d;
    logic signed [IW-1:0] integ_t_q, integ_t_d;
    logic signed [31:0]   p_q, p_d;
    logic signed [31:0]   i_q, i_d;
    logic signed [31:0]   u_q, u_d;
    logic [10:0]          duty_shadow_q, duty_shadow_d;
    logic                 dir_shadow_q, dir_shadow_d;
    logic [10:0]          duty_active_q, duty_active_d;
    logic                 motor_dir_q, motor_dir_d;
    logic                 pwm_q, pwm_d;
    logic                 sat_q, sat_d;
    logic                 update_done_q, update_done_d;

    // Datapath helpers
    logic                 tick;
    logic signed [12:0]   err_calc;
    logic signed [IW-1:0] integ_sum;
    logic signed [IW-1:0] integ_clamped;
    logic signed [31:0]   err_ext;
    logic signed [31:0]   integ_t_ext;
    logic signed [31:0]   pi_sum;
    logic [31:0]          u_abs;
    logic                 sat_calc;
    logic [10:0]          mag;
    logic                 aw_hold;

    assign tick = (samp_q == SAMP_LAST);

    // 13-bit difference of two 12-bit signed values cannot overflow.
    assign err_calc = {vel_cmd[11], vel_cmd} - {vel_meas[11], vel_meas};

    assign integ_sum     = integ_q + {{(IW - 13){err_calc[12]}}, err_calc};
    assign integ_clamped = (integ_sum > INT_MAX) ? INT_MAX :
                           (integ_sum < INT_MIN) ? INT_MIN : integ_sum;

    assign err_ext     = {{19{err_q[12]}}, err_q};
    assign integ_t_ext = {{(32 - IW){integ_t_q[IW-1]}}, integ_t_q};
    assign pi_sum      = p_q + i_q;

    assign u_abs    = u_q[31] ? 32'(-u_q) : 32'(u_q);
    assign sat_calc = (u_abs > DUTY_MAX32);
    assign mag      = sat_calc ? DUTY_MAX : u_abs[10:0];

    // Anti-windup: when the output is clamped and the error pushes further
    // into the clamp, the integrator keeps its previous value.
    assign aw_hold = sat_calc && (err_q[12] == u_q[31]);

    always_comb begin
        state_d       = state_q;
        samp_d        = (samp_q == SAMP_LAST) ? '0 : samp_q + 1'b1;
        cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        err_d         = err_q;
        integ_d       = integ_q;
        integ_t_d     = integ_t_q;
        p_d           = p_q;
        i_d           = i_q;
        u_d           = u_q;
        duty_shadow_d = duty_shadow_q;
        dir_shadow_d  = dir_shadow_q;
        duty_active_d = duty_active_q;
        motor_dir_d   = motor_dir_q;
        sat_d         = sat_q;
        update_done_d = 1'b0;
        pwm_d         = enable && (32'(cnt_q) < 32'(duty_active_q));

        case (state_q)
            S_IDLE: begin
                if (tick && enable) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                err_d     = err_calc;
                integ_t_d = integ_clamped;
                state_d   = S_MUL;
            end
            S_MUL: begin
                p_d     = KP_S * err_ext;
                i_d     = KI_S * integ_t_ext;
                state_d = S_SUM;
            end
            S_SUM: begin
                // Arithmetic shift floors negative values toward -inf.
                u_d     = pi_sum >>> FRAC_BITS;
                state_d = S_CLAMP;
            end
            S_CLAMP: begin
                duty_shadow_d = mag;
                dir_shadow_d  = ~u_q[31];
                sat_d         = sat_calc;
                if (!aw_hold) begin
                    integ_d = integ_t_q;
                end
                update_done_d = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Period boundary: the shadow registers are read as _q values, so a
        // shadow write on this same edge is picked up one period later.
        if (cnt_q == CNT_LAST) begin
            if ((dir_shadow_q != motor_dir_q) && (duty_shadow_q != '0)) begin
                // Reversal: flip the bridge with one full period of zero drive.
                // The new duty loads at the next boundary, when the
                // directions already agree.
                motor_dir_d   = dir_shadow_q;
                duty_active_d = '0;
            end else begin
                // Direction only matters with nonzero drive. A zero duty
                // therefore leaves the bridge where it is.
                duty_active_d = duty_shadow_q;
            end
        end

        if (!enable) begin
            state_d       = S_IDLE;
            integ_d       = '0;
            duty_shadow_d = '0;
            dir_shadow_d  = 1'b0;
            duty_active_d = '0;
            motor_dir_d   = motor_dir_q;
            update_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            samp_q        <= '0;
            cnt_q         <= '0;
            err_q         <= '0;
            integ_q       <= '0;
            integ_t_q     <= '0;
            p_q           <= '0;
            i_q           <= '0;
            u_q           <= '0;
            duty_shadow_q <= '0;
            dir_shadow_q  <= 1'b0;
            duty_active_q <= '0;
            motor_dir_q   <= 1'b0;
            pwm_q         <= 1'b0;
            sat_q         <= 1'b0;
            update_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            samp_q        <= samp_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            integ_q       <= integ_d;
            integ_t_q     <= integ_t_d;
            p_q           <= p_d;
            i_q           <= i_d;
            u_q           <= u_d;
            duty_shadow_q <= duty_shadow_d;
            dir_shadow_q  <= dir_shadow_d;
            duty_active_q <= duty_active_d;
            motor_dir_q   <= motor_dir_d;
            pwm_q         <= pwm_d;
            sat_q         <= sat_d;
            update_done_q <= update_done_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign motor_dir   = motor_dir_q;
    assign duty        = duty_active_q;
    assign sat         = sat_q;
    assign update_done = update_done_q;

endmodule
